// File: rtl/sar_pkg.sv
// Shared types for the SAR ADC controller: FSM state encoding and the
// channel-select width helper.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_ACC,
    ST_DONE
  } sar_state_e;

  // A single-channel mux still needs a one-bit select port.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_bit_seq.sv
// Successive-approximation trial/keep register with MSB-first bit pointer.
// load seeds the MSB trial; each step resolves the current bit and trials the next.
module sar_bit_seq #(
  parameter int NBITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             comp,
  output logic [NBITS-1:0] code,
  output logic             last
);

  localparam int PW = $clog2(NBITS);

  logic [NBITS-1:0] code_q, code_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  always_comb begin
    code_d = code_q;
    ptr_d  = ptr_q;
    if (load) begin
      code_d = {1'b1, {(NBITS-1){1'b0}}};
      ptr_d  = PW'(NBITS-1);
    end else if (step) begin
      code_d[ptr_q] = comp;
      if (ptr_q != '0) begin
        code_d[ptr_q - 1'b1] = 1'b1;
        ptr_d                = ptr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      ptr_q  <= '0;
    end else begin
      code_q <= code_d;
      ptr_q  <= ptr_d;
    end
  end

  assign code = code_q;
  assign last = (ptr_q == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: sample/convert/accumulate FSM driving the
// comparator + capacitive DAC macro, with optional 2^avg averaging and a
// valid/ready result port.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter  int NBITS      = 10,
  parameter  int NCH        = 4,
  parameter  int SAMPLE_CYC = 4,
  parameter  int SETTLE_CYC = 1,
  parameter  int AVG_LOG2   = 0,
  localparam int CHW        = chw(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [CHW-1:0]   ch_sel,
  input  logic [2:0]       avg_sel,
  input  logic [4:0]       trim_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NBITS-1:0] res_data,
  output logic [CHW-1:0]   res_ch,
  output logic [CHW-1:0]   mux_sel,
  output logic             sample,
  output logic [NBITS-1:0] ctlp,
  output logic [NBITS-1:0] ctln,
  output logic             clkc,
  output logic [4:0]       trim,
  output logic [4:0]       trimb,
  input  logic             comp
);

  localparam int SUMW   = NBITS + AVG_LOG2;
  localparam int CNT_MX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNTW   = $clog2(CNT_MX + 1);

  sar_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [4:0]       conv_q, conv_d;
  logic [2:0]       avg_q, avg_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [4:0]       trim_q, trim_d;
  logic [SUMW-1:0]  sum_q, sum_d;
  logic             res_valid_q, res_valid_d;
  logic [NBITS-1:0] res_data_q, res_data_d;
  logic [CHW-1:0]   res_ch_q, res_ch_d;
  logic             sample_q, sample_d;
  logic             clkc_q, clkc_d;
  logic             comp_q;

  logic             load, step, last;
  logic [NBITS-1:0] code;

  sar_bit_seq #(.NBITS(NBITS)) u_bit_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .comp  (comp_q),
    .code  (code),
    .last  (last)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    conv_d      = conv_q;
    avg_d       = avg_q;
    ch_d        = ch_q;
    trim_d      = trim_q;
    sum_d       = sum_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    load        = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
          conv_d  = '0;
          sum_d   = '0;
          avg_d   = (avg_sel > 3'(AVG_LOG2)) ? 3'(AVG_LOG2) : avg_sel;
          ch_d    = (int'(ch_sel) >= NCH) ? CHW'(NCH-1) : ch_sel;
          trim_d  = trim_in;
          load    = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == CNTW'(SAMPLE_CYC-1)) begin
          state_d = ST_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONV: begin
        // Last count of each bit is the strobe cycle; its closing edge resolves the bit.
        if (cnt_q == CNTW'(SETTLE_CYC)) begin
          step  = 1'b1;
          cnt_d = '0;
          if (last) state_d = ST_ACC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACC: begin
        sum_d = sum_q + SUMW'(code);
        if (conv_q == ((5'd1 << avg_q) - 5'd1)) begin
          state_d = ST_DONE;
        end else begin
          conv_d  = conv_q + 1'b1;
          state_d = ST_SAMPLE;
          load    = 1'b1;
        end
      end
      ST_DONE: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = NBITS'(sum_q >> avg_q);
          res_ch_d    = ch_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Analog strobes are decoded from next-state so they come straight off flops.
    sample_d = (state_d == ST_SAMPLE);
    clkc_d   = (state_d == ST_CONV) && (cnt_d == CNTW'(SETTLE_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      conv_q      <= '0;
      avg_q       <= '0;
      ch_q        <= '0;
      trim_q      <= '0;
      sum_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      sample_q    <= 1'b0;
      clkc_q      <= 1'b0;
      comp_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      conv_q      <= conv_d;
      avg_q       <= avg_d;
      ch_q        <= ch_d;
      trim_q      <= trim_d;
      sum_q       <= sum_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      sample_q    <= sample_d;
      clkc_q      <= clkc_d;
      comp_q      <= comp;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign mux_sel   = ch_q;
  assign sample    = sample_q;
  assign ctlp      = code;
  assign ctln      = ~code;
  assign clkc      = clkc_q;
  assign trim      = trim_q;
  assign trimb     = ~trim_q;

endmodule
